// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter8_dec.sv
// Team 3-to-8 decoder: one-hot output of in when en is high, all zeros otherwise.
module rr_arbiter8_dec (
  input  logic       en,
  input  logic [2:0] in,
  output logic [7:0] out
);

  always_comb begin
    out = 8'h00;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered grant index and optional
// hold timer that forces rotation when an owner keeps the resource too long.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy
);

  localparam bit              PREEMPT_ON = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = PREEMPT_ON ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] owner_mask;
  logic               preempt;
  logic               release_now;

  // Scan from the highest offset down so the offset closest to ptr wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] k;
    rr_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = p + IDX_W'(i);
      if (r[k]) rr_pick = {1'b1, k};
    end
  endfunction

  assign {win_found, win_idx} = rr_pick(req, ptr_q);

  assign owner_mask  = NUM_REQ'(1) << idx_q;
  assign preempt     = PREEMPT_ON && (cnt_q == HOLD_LAST) && |(req & ~owner_mask);
  assign release_now = !en || !req[idx_q] || preempt;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en && win_found) begin
          idx_d   = win_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          ptr_d   = idx_q + 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_idx = idx_q;
  assign gnt_en  = (state_q == GRANT);
  assign busy    = gnt_en;

  rr_arbiter8_dec u_dec (
    .en  (gnt_en),
    .in  (gnt_idx),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 (MAX_HOLD=4): directed vectors push the
// expected post-edge outputs; a negedge monitor pops and compares them.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;
  logic [2:0] gnt_idx;
  logic       gnt_en;
  logic [7:0] gnt;
  logic       busy;

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .gnt     (gnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    int         due;
    logic       chk_idx;
    logic       xen;
    logic [2:0] xidx;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   vec_id = 0;
  bit   soak   = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: outputs are stable at the negedge; pop every expectation due now.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] xgnt;
    if (soak) check("soak onehot", {7'd0, ($countones(gnt) <= 1)}, 8'd1);
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e    = exp_q.pop_front();
      xgnt = e.xen ? (8'd1 << e.xidx) : 8'h00;
      check($sformatf("v%0d gnt_en", e.id), {7'd0, gnt_en}, {7'd0, e.xen});
      check($sformatf("v%0d busy", e.id),   {7'd0, busy},   {7'd0, e.xen});
      check($sformatf("v%0d gnt", e.id),    gnt,            xgnt);
      if (e.chk_idx) check($sformatf("v%0d gnt_idx", e.id), {5'd0, gnt_idx}, {5'd0, e.xidx});
    end
  end

  // Apply inputs for one edge and record the outputs expected after that edge.
  task automatic vec(input logic r, input logic e, input logic [7:0] q,
                     input logic xen, input logic [2:0] xidx);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    en  = e;
    req = q;
    vec_id++;
    x.id      = vec_id;
    x.due     = cyc + 1;
    x.chk_idx = xen | r;
    x.xen     = xen;
    x.xidx    = xidx;
    exp_q.push_back(x);
  endtask

  initial begin
    // Reset with all requesting, then first grant to 0; drop 0 -> dead cycle -> 1.
    vec(1, 1, 8'hFF, 0, 0);
    vec(1, 1, 8'hFF, 0, 0);
    vec(0, 1, 8'hFF, 1, 0);
    vec(0, 1, 8'hFE, 0, 0);
    vec(0, 1, 8'hFE, 1, 1);
    vec(0, 1, 8'h00, 0, 0);

    // Wrap: 0,7,0,7 with one idle cycle between owners.
    vec(1, 1, 8'h00, 0, 0);
    vec(0, 1, 8'h81, 1, 0);
    vec(0, 1, 8'h80, 0, 0);
    vec(0, 1, 8'h81, 1, 7);
    vec(0, 1, 8'h01, 0, 0);
    vec(0, 1, 8'h81, 1, 0);
    vec(0, 1, 8'h80, 0, 0);
    vec(0, 1, 8'h81, 1, 7);
    vec(0, 1, 8'h00, 0, 0);
    vec(0, 1, 8'h00, 0, 0);

    // Hold timer: 2 for 4 cycles, idle, 3 for 4 cycles, idle, 2 again.
    for (int i = 0; i < 4; i++) vec(0, 1, 8'h0C, 1, 2);
    vec(0, 1, 8'h0C, 0, 0);
    for (int i = 0; i < 4; i++) vec(0, 1, 8'h0C, 1, 3);
    vec(0, 1, 8'h0C, 0, 0);
    vec(0, 1, 8'h0C, 1, 2);
    vec(0, 1, 8'h00, 0, 0);

    // Lone requester 5 is never preempted.
    for (int i = 0; i < 20; i++) vec(0, 1, 8'h20, 1, 5);
    // EN low releases and advances ptr to 6; 0 then wins over 5 via wrap.
    vec(0, 0, 8'h20, 0, 0);
    vec(0, 1, 8'h21, 1, 0);
    vec(0, 1, 8'h00, 0, 0);

    // Reset mid-grant of owner 4 drops the grant and clears ptr.
    vec(0, 1, 8'h10, 1, 4);
    vec(0, 1, 8'h10, 1, 4);
    vec(1, 1, 8'h10, 0, 0);
    vec(0, 0, 8'hFF, 0, 0);
    vec(0, 1, 8'hFF, 1, 0);
    vec(0, 1, 8'h00, 0, 0);

    // Random soak: grant must be one-hot or zero every cycle.
    @(posedge clk);
    #1;
    soak = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req = 8'($urandom);
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 63) == 0);
      @(posedge clk);
      #1;
    end
    soak = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
